// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store path.
// Contents: op encodings, FSM state enum, access-size enum and small decode helpers
// (is_load, is_store, op_size, is_misaligned).
package mips_mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b011,
    OP_LHU = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StResp,
    StErr
  } state_e;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } size_e;

  function automatic logic is_load(op_e op);
    return (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
  endfunction

  function automatic logic is_store(op_e op);
    return (op inside {OP_SB, OP_SH, OP_SW});
  endfunction

  function automatic size_e op_size(op_e op);
    size_e sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SzByte;
      OP_LH, OP_LHU, OP_SH: sz = SzHalf;
      default:              sz = SzWord;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(op_e op, logic [1:0] off);
    logic mis;
    case (op_size(op))
      SzWord:  mis = (off != 2'b00);
      SzHalf:  mis = off[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for a big-endian 32-bit word.
// Ports:
//   i_op          access op (selects extract width/extension and merge width)
//   i_offset      byte offset inside the word (already force-aligned for halves)
//   i_word        word read from memory
//   i_wdata       store data (SB uses [7:0], SH uses [15:0])
//   o_load_data   extracted and sign/zero-extended load result
//   o_merge_data  i_word with the store lane(s) replaced by i_wdata
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  op_e         i_op,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Offset 0 is the most significant byte (big-endian).
  always_comb begin
    w_byte = i_word[31:24];
    unique case (i_offset)
      2'd0: w_byte = i_word[31:24];
      2'd1: w_byte = i_word[23:16];
      2'd2: w_byte = i_word[15:8];
      2'd3: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];
  end

  always_comb begin
    o_load_data = i_word;
    case (i_op)
      OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load_data = {24'h0, w_byte};
      OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load_data = {16'h0, w_half};
      default: o_load_data = i_word;
    endcase
  end

  always_comb begin
    o_merge_data = i_word;
    if (i_op == OP_SB) begin
      unique case (i_offset)
        2'd0: o_merge_data[31:24] = i_wdata[7:0];
        2'd1: o_merge_data[23:16] = i_wdata[7:0];
        2'd2: o_merge_data[15:8]  = i_wdata[7:0];
        2'd3: o_merge_data[7:0]   = i_wdata[7:0];
      endcase
    end else if (i_op == OP_SH) begin
      if (i_offset[1]) begin
        o_merge_data[15:0] = i_wdata[15:0];
      end else begin
        o_merge_data[31:16] = i_wdata[15:0];
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer in front of a word-wide big-endian data memory.
// Sub-word stores are read-modify-write since the memory always writes 4 bytes.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_req_valid/o_req_ready          request handshake (ready only when idle)
//   i_req_op/addr/wdata/rd           request fields, latched on accept
//   o_resp_valid                     one-cycle completion pulse
//   o_resp_is_load/err/data/rd       response fields, valid with o_resp_valid
//   o_mem_addr/rd/wr/wdata           data memory control (address always word aligned)
//   i_mem_rdata                      data memory read data, sampled only while o_mem_rd
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_req_op,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [4:0]        i_req_rd,
  output logic              o_resp_valid,
  output logic              o_resp_is_load,
  output logic              o_resp_err,
  output logic [31:0]       o_resp_data,
  output logic [4:0]        o_resp_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  state_e            r_state, w_state_d;
  op_e               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic [4:0]        r_rd;
  logic [31:0]       r_resp_data;
  logic [31:0]       r_mem_wdata;

  op_e         w_op;
  logic        w_accept;
  logic [1:0]  w_eff_off;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  assign w_op     = op_e'(i_req_op);
  assign w_accept = i_req_valid && (r_state == StIdle);

  // Lane offset with misalignment forced away; only reaches the lanes when CHECK_ALIGN=0.
  always_comb begin
    w_eff_off = i_req_addr[1:0];
    case (op_size(w_op))
      SzHalf:  w_eff_off = {i_req_addr[1], 1'b0};
      SzWord:  w_eff_off = 2'b00;
      default: w_eff_off = i_req_addr[1:0];
    endcase
  end

  lsu_lane_align u_lane_align (
    .i_op         (r_op),
    .i_offset     (r_off),
    .i_word       (i_mem_rdata),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (CHECK_ALIGN && is_misaligned(w_op, i_req_addr[1:0])) begin
            w_state_d = StErr;
          end else if (w_op == OP_SW) begin
            w_state_d = StWr;
          end else begin
            w_state_d = StRd;
          end
        end
      end
      StRd:    w_state_d = is_load(r_op) ? StResp : StWr;
      StWr:    w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_op        <= OP_LB;
      r_addr      <= '0;
      r_off       <= 2'b00;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_resp_data <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_op        <= w_op;
        r_addr      <= i_req_addr;
        r_off       <= w_eff_off;
        r_wdata     <= i_req_wdata;
        r_rd        <= i_req_rd;
        r_resp_data <= '0;
        // SW goes straight to WR, so its write word is the request data itself.
        r_mem_wdata <= i_req_wdata;
      end
      if (r_state == StRd) begin
        r_resp_data <= is_load(r_op) ? w_load_data : 32'h0;
        r_mem_wdata <= w_merge_data;
      end
    end
  end

  assign o_req_ready    = (r_state == StIdle);
  assign o_mem_rd       = (r_state == StRd);
  assign o_mem_wr       = (r_state == StWr);
  assign o_mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_mem_wdata    = r_mem_wdata;
  assign o_resp_valid   = (r_state == StResp) || (r_state == StErr);
  assign o_resp_err     = (r_state == StErr);
  assign o_resp_is_load = o_resp_valid && is_load(r_op);
  assign o_resp_data    = (r_state == StResp) ? r_resp_data : 32'h0;
  assign o_resp_rd      = o_resp_valid ? r_rd : 5'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array data memory, a word-level reference model of the
// expected per-cycle behaviour, one per-cycle compare process and literal spot checks.
module tb_mem_access_unit;

  localparam logic [2:0] L_LB = 3'b000, L_LH = 3'b001, L_LW = 3'b010, L_LBU = 3'b011;
  localparam logic [2:0] L_LHU = 3'b100, L_SB = 3'b101, L_SH = 3'b110, L_SW = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid, resp_is_load, resp_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [11:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit #(
    .ADDR_W      (12),
    .CHECK_ALIGN (1'b1)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_op       (req_op),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_rd       (req_rd),
    .o_resp_valid   (resp_valid),
    .o_resp_is_load (resp_is_load),
    .o_resp_err     (resp_err),
    .o_resp_data    (resp_data),
    .o_resp_rd      (resp_rd),
    .o_mem_addr     (mem_addr),
    .o_mem_rd       (mem_rd),
    .o_mem_wr       (mem_wr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: big-endian bytes, word read/write. Preload shares the write port.
  logic [7:0]  dmem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_word = '0;
  int          ra;
  assign ra = int'(mem_addr);

  always @(posedge clk) begin
    if (mem_wr) begin
      {dmem[ra], dmem[ra+1], dmem[ra+2], dmem[ra+3]} <= mem_wdata;
    end else if (pl_en) begin
      {dmem[int'(pl_addr)], dmem[int'(pl_addr)+1], dmem[int'(pl_addr)+2],
       dmem[int'(pl_addr)+3]} <= pl_word;
    end
  end

  // Junk when not reading, so sampling outside the read cycle shows up.
  always_comb begin
    mem_rdata = 32'hA5A5A5A5;
    if (mem_rd) mem_rdata = {dmem[ra], dmem[ra+1], dmem[ra+2], dmem[ra+3]};
  end

  // Reference model state: word image and expected event cycles for the current transaction.
  logic [31:0] mm [1024];
  int          e_c0 = -10, e_busy_end = -10, e_resp = -10, e_rdc = -10, e_wrc = -10;
  logic [11:0] e_addr = '0;
  logic [31:0] e_wdata = '0, e_data = '0;
  logic        e_err = 1'b0, e_isload = 1'b0;
  logic [4:0]  e_rd = '0;
  logic        pend_valid = 1'b0;
  int          pend_idx = 0;
  logic [31:0] pend_word = '0;
  logic [31:0] last_data = '0;
  logic        chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("resp_valid", 32'(resp_valid), 32'(cyc == e_resp));
      if (cyc == e_resp) begin
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("resp_is_load", 32'(resp_is_load), 32'(e_isload));
        chk("resp_data", resp_data, e_data);
        chk("resp_rd", 32'(resp_rd), 32'(e_rd));
        last_data = resp_data;
      end
      chk("mem_rd", 32'(mem_rd), 32'(cyc == e_rdc));
      chk("mem_wr", 32'(mem_wr), 32'(cyc == e_wrc));
      if (cyc == e_rdc || cyc == e_wrc) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (cyc == e_wrc) chk("mem_wdata", mem_wdata, e_wdata);
      chk("req_ready", 32'(req_ready), 32'(!(cyc > e_c0 && cyc <= e_busy_end)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic commit();
    if (pend_valid) mm[pend_idx] = pend_word;
    pend_valid = 1'b0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] w);
    pl_en = 1'b1; pl_addr = a; pl_word = w;
    mm[int'(a[11:2])] = w;
    step();
    pl_en = 1'b0;
  endtask

  // Present a request, wait (bounded) for acceptance, and set up the expected behaviour.
  task automatic issue(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                       input logic [4:0] rd);
    int          guard;
    int          o;
    logic [31:0] w;
    logic [7:0]  b [4];
    logic [15:0] h;
    logic        mis;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_rd = rd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    commit();
    w = mm[int'(a[11:2])];
    o = int'(a[1:0]);
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    if (op == L_LW || op == L_SW) mis = (o != 0);
    else if (op == L_LH || op == L_LHU || op == L_SH) mis = (o % 2 == 1);
    else mis = 1'b0;
    e_c0 = cyc; e_addr = {a[11:2], 2'b00}; e_rd = rd; e_err = mis;
    e_isload = (op <= L_LHU); e_rdc = -10; e_wrc = -10; e_data = 32'h0;
    if (mis) begin
      e_resp = cyc + 1;
    end else if (op <= L_LHU) begin
      e_rdc = cyc + 1; e_resp = cyc + 2;
      h = (o >= 2) ? {b[2], b[3]} : {b[0], b[1]};
      case (op)
        L_LB:    e_data = 32'($signed(b[o]));
        L_LBU:   e_data = 32'(b[o]);
        L_LH:    e_data = 32'($signed(h));
        L_LHU:   e_data = 32'(h);
        default: e_data = w;
      endcase
    end else if (op == L_SW) begin
      e_wrc = cyc + 1; e_resp = cyc + 2; e_wdata = wd;
      pend_valid = 1'b1; pend_idx = int'(a[11:2]); pend_word = wd;
    end else begin
      if (op == L_SB) begin
        b[o] = wd[7:0];
      end else begin
        b[o] = wd[15:8]; b[o+1] = wd[7:0];
      end
      e_rdc = cyc + 1; e_wrc = cyc + 2; e_resp = cyc + 3;
      e_wdata = {b[0], b[1], b[2], b[3]};
      pend_valid = 1'b1; pend_idx = int'(a[11:2]); pend_word = e_wdata;
    end
    e_busy_end = e_resp;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (cyc <= e_busy_end && guard < 20) begin
      step();
      guard++;
    end
    if (cyc <= e_busy_end) chk("done_timeout", 32'd0, 32'd1);
    commit();
  endtask

  function automatic logic [31:0] dword(input int a);
    return {dmem[a], dmem[a+1], dmem[a+2], dmem[a+3]};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_is_load", 32'(resp_is_load), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_rd", 32'(resp_rd), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk_en = 1'b1;
    step();

    // Word store then load back.
    issue(L_SW, 12'h010, 32'h11223344, 5'd1); wait_done();
    issue(L_LW, 12'h010, 32'h0, 5'd2);        wait_done();
    chk("lit_lw_010", last_data, 32'h11223344);

    // Sub-word loads with sign/zero extension.
    preload(12'h020, 32'h80FF7F01);
    issue(L_LB, 12'h020, 32'h0, 5'd3);  wait_done(); chk("lit_lb_020", last_data, 32'hFFFFFF80);
    issue(L_LBU, 12'h021, 32'h0, 5'd4); wait_done(); chk("lit_lbu_021", last_data, 32'h000000FF);
    issue(L_LB, 12'h022, 32'h0, 5'd5);  wait_done(); chk("lit_lb_022", last_data, 32'h0000007F);
    issue(L_LH, 12'h022, 32'h0, 5'd6);  wait_done(); chk("lit_lh_022", last_data, 32'h00007F01);
    issue(L_LHU, 12'h020, 32'h0, 5'd7); wait_done(); chk("lit_lhu_020", last_data, 32'h000080FF);

    // Read-modify-write stores.
    preload(12'h020, 32'h11223344);
    issue(L_SB, 12'h023, 32'h000000AB, 5'd8); wait_done();
    chk("lit_sb_023", dword(32'h020), 32'h112233AB);
    issue(L_SH, 12'h020, 32'h0000BEEF, 5'd9); wait_done();
    chk("lit_sh_020", dword(32'h020), 32'hBEEF33AB);

    // Misaligned accesses.
    issue(L_LW, 12'h011, 32'h0, 5'd10);       wait_done();
    issue(L_SH, 12'h013, 32'h0000DEAD, 5'd11); wait_done();

    // Reset during the read half of an RMW.
    preload(12'h030, 32'h55667788);
    issue(L_SB, 12'h030, 32'h000000EE, 5'd12);
    rst = 1'b1;
    e_resp = -10; e_wrc = -10; e_busy_end = cyc; pend_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    step();

    // Top word.
    preload(12'hFFC, 32'hCAFEF00D);
    issue(L_LW, 12'hFFC, 32'h0, 5'd13); wait_done();
    chk("lit_lw_ffc", last_data, 32'hCAFEF00D);

    // Back-to-back requests with valid held.
    issue(L_SW, 12'h040, 32'h0BADF00D, 5'd14);
    issue(L_LW, 12'h040, 32'h0, 5'd15);
    issue(L_LBU, 12'hFFF, 32'h0, 5'd16);
    issue(L_LH, 12'hFFE, 32'h0, 5'd17);
    issue(L_SB, 12'hFFD, 32'h00000042, 5'd18);
    wait_done();
    step();

    chk("mem_010", dword(32'h010), 32'h11223344);
    chk("mem_020", dword(32'h020), 32'hBEEF33AB);
    chk("mem_030", dword(32'h030), 32'h55667788);
    chk("mem_040", dword(32'h040), 32'h0BADF00D);
    chk("mem_ffc", dword(32'hFFC), 32'hCA42F00D);
    chk("model_ffc", dword(32'hFFC), mm[1023]);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
